seq_packet_packer: RTL and testbench
====================================

// Module: seq_packet_packer
// PURPOSE
// - Packs single LZ sequences (ll/ml/offset) from one match-engine job into SEQ_PACKET_SIZE-lane packets.
// - Output format (mask/ll/ml/offset/overlap/eoj/delim) drives the local_i_* side of the sequence packet bus node.
// - Closes a packet when all lanes are filled or on a sequence carrying eoj or delim; partial packets set only the low mask bits.
// PARAMETERS
// - PACKET_SIZE   `SEQ_PACKET_SIZE   lanes per packet (>=2)
// - LL_BITS       `SEQ_LL_BITS       literal-length width per lane
// - ML_BITS       `SEQ_ML_BITS       match-length width per lane and overlap width
// - OFFSET_BITS   `SEQ_OFFSET_BITS   offset width per lane
// - TIMEOUT       64                 idle cycles before forced flush (only with SEQ_PACKER_TIMEOUT_EN)
// PORTS
// - clk            in   1                      clock, all logic on rising edge
// - rst_n          in   1                      asynchronous active-low reset
// - seq_i_valid    in   1                      input sequence valid
// - seq_i_ll       in   LL_BITS                literal length
// - seq_i_ml       in   ML_BITS                match length
// - seq_i_offset   in   OFFSET_BITS            match offset
// - seq_i_overlap  in   ML_BITS                job overlap; meaningful only when seq_i_eoj=1
// - seq_i_eoj      in   1                      last sequence of the job
// - seq_i_delim    in   1                      block delimiter after this sequence
// - seq_i_ready    out  1                      input accept
// - pkt_o_valid    out  1                      packet valid (to local_i_valid)
// - pkt_o_mask     out  PACKET_SIZE            lane valid bits, contiguous from bit 0
// - pkt_o_ll       out  LL_BITS*PACKET_SIZE    lane i at [i*LL_BITS +: LL_BITS]
// - pkt_o_ml       out  ML_BITS*PACKET_SIZE    lane i at [i*ML_BITS +: ML_BITS]
// - pkt_o_offset   out  OFFSET_BITS*PACKET_SIZE  lane i at [i*OFFSET_BITS +: OFFSET_BITS]
// - pkt_o_overlap  out  ML_BITS                overlap of the eoj sequence, else 0
// - pkt_o_eoj      out  1                      packet ends the job
// - pkt_o_delim    out  1                      packet ends with a delimiter
// - pkt_o_ready    in   1                      downstream accept
// BEHAVIOUR
// - Storage: assembly buffer (lanes, lane count cnt 0..PACKET_SIZE-1, pending flag) plus one output register.
// - Reset: cnt=0, pending=0, pkt_o_valid=0, all pkt_o_* fields=0; seq_i_ready=1 in the cycle after reset release.
// - Lane fill: an accepted sequence (seq_i_valid & seq_i_ready) writes lane cnt.
//   - Close condition: cnt==PACKET_SIZE-1, or seq_i_eoj, or seq_i_delim.
//   - Non-closing accept: cnt increments.
// - Load rule on a closing accept:
//   - Output free (!pkt_o_valid | pkt_o_ready): output register loads the assembled lanes plus the closing sequence; cnt resets to 0. Latency 1 cycle.
//   - Output busy: pending=1.
// - Pending: seq_i_ready=0; the packet moves to the output in the first cycle with pkt_o_valid=0 or pkt_o_ready=1; pending and cnt clear.
// - seq_i_ready = !pending. Combinational from registers only; no path from pkt_o_ready.
// - Throughput: full packets stream with no input bubbles while pkt_o_ready=1.
// - mask = (1<<lanes)-1. Unused lanes hold 0 for ll/ml/offset.
// - eoj, delim and overlap come from the closing sequence. overlap is 0 unless eoj=1.
// - eoj and delim together: one packet with both flags set.
// - Output stability: pkt_o_* hold stable while pkt_o_valid=1 and pkt_o_ready=0.
// - Asynchronous reset mid-packet discards the assembly and output contents immediately.
// CONFIGURATION
// - SEQ_PACKER_TIMEOUT_EN defined:
//   - 8-bit idle counter increments while cnt>0, !pending and no accept; it clears on any accept.
//   - When it reaches TIMEOUT, the partial packet closes as if pending (eoj=0, delim=0, overlap=0).
// - Undefined: partial packets close only on eoj/delim; no counter logic is built.
// TESTING (bench uses PACKET_SIZE=4)
// - 8 seqs, no eoj/delim, pkt_o_ready=1 -> 2 packets, mask=4'b1111, lanes in order, seq_i_ready never 0.
// - 3 seqs, 3rd eoj=1 overlap=5 -> 1 packet mask=4'b0111, eoj=1, overlap=5, lane3 fields=0.
// - 1 seq with eoj=1 delim=1 -> mask=4'b0001, eoj=1, delim=1, pkt_o_valid 1 cycle after accept.
// - pkt_o_ready=0, 12 seqs offered -> one packet in output, second pending, seq_i_ready=0 after 8 accepts; outputs stable; release -> order preserved.
// - Reset asserted with cnt=2 and pkt_o_valid=1 -> pkt_o_valid=0 at once; a following 4-seq burst gives mask=4'b1111.
// - TIMEOUT_EN, TIMEOUT=64: 2 seqs then idle -> packet mask=4'b0011, eoj=0, valid 64 cycles after last accept (+1 load).

Source files
------------

// File: rtl/seq_packet_packer.sv
// Packs LZ sequences (ll/ml/offset) from one job into PACKET_SIZE-lane packets.
// Optional idle-flush of partial packets: define SEQ_PACKER_TIMEOUT_EN.
`ifndef SEQ_PACKET_SIZE
`define SEQ_PACKET_SIZE 4
`endif
`ifndef SEQ_LL_BITS
`define SEQ_LL_BITS 16
`endif
`ifndef SEQ_ML_BITS
`define SEQ_ML_BITS 16
`endif
`ifndef SEQ_OFFSET_BITS
`define SEQ_OFFSET_BITS 16
`endif

module seq_packet_packer #(
    parameter int PACKET_SIZE = `SEQ_PACKET_SIZE,
    parameter int LL_BITS     = `SEQ_LL_BITS,
    parameter int ML_BITS     = `SEQ_ML_BITS,
    parameter int OFFSET_BITS = `SEQ_OFFSET_BITS,
    parameter int TIMEOUT     = 64
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               seq_i_valid,
    input  logic [LL_BITS-1:0]                 seq_i_ll,
    input  logic [ML_BITS-1:0]                 seq_i_ml,
    input  logic [OFFSET_BITS-1:0]             seq_i_offset,
    input  logic [ML_BITS-1:0]                 seq_i_overlap,
    input  logic                               seq_i_eoj,
    input  logic                               seq_i_delim,
    output logic                               seq_i_ready,
    output logic                               pkt_o_valid,
    output logic [PACKET_SIZE-1:0]             pkt_o_mask,
    output logic [LL_BITS*PACKET_SIZE-1:0]     pkt_o_ll,
    output logic [ML_BITS*PACKET_SIZE-1:0]     pkt_o_ml,
    output logic [OFFSET_BITS*PACKET_SIZE-1:0] pkt_o_offset,
    output logic [ML_BITS-1:0]                 pkt_o_overlap,
    output logic                               pkt_o_eoj,
    output logic                               pkt_o_delim,
    input  logic                               pkt_o_ready
);

    localparam int CW = $clog2(PACKET_SIZE);
    localparam int NW = $clog2(PACKET_SIZE + 1);

    logic [LL_BITS-1:0]     asm_ll  [PACKET_SIZE];
    logic [ML_BITS-1:0]     asm_ml  [PACKET_SIZE];
    logic [OFFSET_BITS-1:0] asm_off [PACKET_SIZE];
    logic [CW-1:0]          cnt;
    logic                   pending;
    logic [NW-1:0]          pend_lanes;
    logic                   pend_eoj;
    logic                   pend_delim;
    logic [ML_BITS-1:0]     pend_overlap;

    logic accept, close, out_free, timeout_hit, load;
    logic [NW-1:0]                      n_lanes;
    logic [PACKET_SIZE-1:0]             bld_mask;
    logic [LL_BITS*PACKET_SIZE-1:0]     bld_ll;
    logic [ML_BITS*PACKET_SIZE-1:0]     bld_ml;
    logic [OFFSET_BITS*PACKET_SIZE-1:0] bld_off;
    logic [ML_BITS-1:0]                 bld_overlap;
    logic                               bld_eoj;
    logic                               bld_delim;

    assign seq_i_ready = ~pending;
    assign accept      = seq_i_valid & ~pending;
    assign close       = accept & ((cnt == CW'(PACKET_SIZE - 1)) | seq_i_eoj | seq_i_delim);
    assign out_free    = ~pkt_o_valid | pkt_o_ready;
    assign load        = out_free & (pending | close | timeout_hit);

`ifdef SEQ_PACKER_TIMEOUT_EN
    logic [7:0] idle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (accept || cnt == '0) begin
            idle_cnt <= '0;
        end else if (!pending && idle_cnt != 8'(TIMEOUT)) begin
            idle_cnt <= idle_cnt + 8'd1;
        end
    end

    assign timeout_hit = (idle_cnt == 8'(TIMEOUT)) & (cnt != '0) & ~pending & ~accept;
`else
    assign timeout_hit = 1'b0;
`endif

    // Packet image as it would leave the buffer this cycle; the accepted
    // sequence (if any) is merged into lane cnt without waiting for the write.
    always_comb begin
        n_lanes     = NW'(cnt);
        bld_eoj     = 1'b0;
        bld_delim   = 1'b0;
        bld_overlap = '0;
        bld_mask    = '0;
        bld_ll      = '0;
        bld_ml      = '0;
        bld_off     = '0;
        if (pending) begin
            n_lanes     = pend_lanes;
            bld_eoj     = pend_eoj;
            bld_delim   = pend_delim;
            bld_overlap = pend_overlap;
        end else if (accept) begin
            n_lanes = NW'(cnt) + NW'(1);
            if (close) begin
                bld_eoj     = seq_i_eoj;
                bld_delim   = seq_i_delim;
                bld_overlap = seq_i_eoj ? seq_i_overlap : '0;
            end
        end
        for (int i = 0; i < PACKET_SIZE; i++) begin
            if (i < int'(n_lanes)) begin
                bld_mask[i] = 1'b1;
                if (accept && i == int'(cnt)) begin
                    bld_ll[i*LL_BITS +: LL_BITS]         = seq_i_ll;
                    bld_ml[i*ML_BITS +: ML_BITS]         = seq_i_ml;
                    bld_off[i*OFFSET_BITS +: OFFSET_BITS] = seq_i_offset;
                end else begin
                    bld_ll[i*LL_BITS +: LL_BITS]         = asm_ll[i];
                    bld_ml[i*ML_BITS +: ML_BITS]         = asm_ml[i];
                    bld_off[i*OFFSET_BITS +: OFFSET_BITS] = asm_off[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PACKET_SIZE; i++) begin
                asm_ll[i]  <= '0;
                asm_ml[i]  <= '0;
                asm_off[i] <= '0;
            end
        end else if (accept) begin
            asm_ll[cnt]  <= seq_i_ll;
            asm_ml[cnt]  <= seq_i_ml;
            asm_off[cnt] <= seq_i_offset;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            pending      <= 1'b0;
            pend_lanes   <= '0;
            pend_eoj     <= 1'b0;
            pend_delim   <= 1'b0;
            pend_overlap <= '0;
        end else if (pending) begin
            if (out_free) begin
                pending <= 1'b0;
                cnt     <= '0;
            end
        end else if (close || timeout_hit) begin
            if (out_free) begin
                cnt <= '0;
            end else begin
                // Closing sequence is already in lane cnt; cnt stays until the move.
                pending      <= 1'b1;
                pend_lanes   <= n_lanes;
                pend_eoj     <= bld_eoj;
                pend_delim   <= bld_delim;
                pend_overlap <= bld_overlap;
            end
        end else if (accept) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_o_valid   <= 1'b0;
            pkt_o_mask    <= '0;
            pkt_o_ll      <= '0;
            pkt_o_ml      <= '0;
            pkt_o_offset  <= '0;
            pkt_o_overlap <= '0;
            pkt_o_eoj     <= 1'b0;
            pkt_o_delim   <= 1'b0;
        end else if (load) begin
            pkt_o_valid   <= 1'b1;
            pkt_o_mask    <= bld_mask;
            pkt_o_ll      <= bld_ll;
            pkt_o_ml      <= bld_ml;
            pkt_o_offset  <= bld_off;
            pkt_o_overlap <= bld_overlap;
            pkt_o_eoj     <= bld_eoj;
            pkt_o_delim   <= bld_delim;
        end else if (pkt_o_ready) begin
            pkt_o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_packet_packer.sv
// Scoreboard bench for seq_packet_packer (4 lanes); reference model groups
// accepted sequences into packets and a monitor checks each delivered packet.
module tb_seq_packet_packer;
    localparam int P  = 4;
    localparam int LB = 8;
    localparam int MB = 8;
    localparam int OB = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic seq_i_valid = 1'b0;
    logic [LB-1:0] seq_i_ll = '0;
    logic [MB-1:0] seq_i_ml = '0;
    logic [OB-1:0] seq_i_offset = '0;
    logic [MB-1:0] seq_i_overlap = '0;
    logic seq_i_eoj = 1'b0;
    logic seq_i_delim = 1'b0;
    logic seq_i_ready;
    logic pkt_o_valid;
    logic [P-1:0] pkt_o_mask;
    logic [LB*P-1:0] pkt_o_ll;
    logic [MB*P-1:0] pkt_o_ml;
    logic [OB*P-1:0] pkt_o_offset;
    logic [MB-1:0] pkt_o_overlap;
    logic pkt_o_eoj;
    logic pkt_o_delim;
    logic pkt_o_ready = 1'b1;

    seq_packet_packer #(.PACKET_SIZE(P), .LL_BITS(LB), .ML_BITS(MB), .OFFSET_BITS(OB), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .seq_i_valid(seq_i_valid), .seq_i_ll(seq_i_ll), .seq_i_ml(seq_i_ml),
        .seq_i_offset(seq_i_offset), .seq_i_overlap(seq_i_overlap),
        .seq_i_eoj(seq_i_eoj), .seq_i_delim(seq_i_delim), .seq_i_ready(seq_i_ready),
        .pkt_o_valid(pkt_o_valid), .pkt_o_mask(pkt_o_mask), .pkt_o_ll(pkt_o_ll),
        .pkt_o_ml(pkt_o_ml), .pkt_o_offset(pkt_o_offset), .pkt_o_overlap(pkt_o_overlap),
        .pkt_o_eoj(pkt_o_eoj), .pkt_o_delim(pkt_o_delim), .pkt_o_ready(pkt_o_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [P-1:0]    mask;
        logic [LB*P-1:0] ll;
        logic [MB*P-1:0] ml;
        logic [OB*P-1:0] off;
        logic [MB-1:0]   ovl;
        logic            eoj;
        logic            delim;
    } pkt_t;

    pkt_t exp_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int stall_cnt = 0;
    int pkts_seen = 0;

    // Reference model: lanes gathered so far in the current packet.
    int m_n = 0;
    logic [LB-1:0] m_ll[P];
    logic [MB-1:0] m_ml[P];
    logic [OB-1:0] m_off[P];

    bit ready_mode = 1'b0;
    bit ready_val = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_emit(input int n, input logic eoj, input logic delim, input logic [MB-1:0] ovl);
        pkt_t p;
        p.mask = '0; p.ll = '0; p.ml = '0; p.off = '0;
        for (int i = 0; i < n; i++) begin
            p.mask[i] = 1'b1;
            p.ll[i*LB +: LB] = m_ll[i];
            p.ml[i*MB +: MB] = m_ml[i];
            p.off[i*OB +: OB] = m_off[i];
        end
        p.ovl = eoj ? ovl : '0;
        p.eoj = eoj;
        p.delim = delim;
        exp_q.push_back(p);
        m_n = 0;
    endfunction

    function automatic void model_accept(input logic [LB-1:0] ll, input logic [MB-1:0] ml,
                                         input logic [OB-1:0] off, input logic [MB-1:0] ovl,
                                         input logic eoj, input logic delim);
        m_ll[m_n] = ll; m_ml[m_n] = ml; m_off[m_n] = off;
        m_n++;
        if (m_n == P || eoj || delim) model_emit(m_n, eoj, delim, ovl);
    endfunction

    // Caller is always just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [LB-1:0] ll, input logic [MB-1:0] ml, input logic [OB-1:0] off,
                        input logic [MB-1:0] ovl, input logic eoj, input logic delim);
        logic rdy;
        seq_i_valid = 1'b1; seq_i_ll = ll; seq_i_ml = ml; seq_i_offset = off;
        seq_i_overlap = ovl; seq_i_eoj = eoj; seq_i_delim = delim;
        for (int w = 0; w < 300; w++) begin
            rdy = seq_i_ready;
            @(posedge clk);
            if (rdy) begin
                model_accept(ll, ml, off, ovl, eoj, delim);
                #1;
                seq_i_valid = 1'b0;
                return;
            end
            stall_cnt++;
            #1;
        end
        chk("send_accept_timeout", 0, 1);
        seq_i_valid = 1'b0;
    endtask

    task automatic send_rand(input int eoj_pct, input int delim_pct);
        send(LB'($urandom), MB'($urandom), OB'($urandom), MB'($urandom),
             ($urandom_range(0, 99) < eoj_pct), ($urandom_range(0, 99) < delim_pct));
    endtask

    task automatic drain(input string name);
        for (int w = 0; w < 400 && exp_q.size() != 0; w++) begin
            @(posedge clk); #1;
        end
        chk(name, exp_q.size(), 0);
    endtask

    always begin
        @(posedge clk);
        #2;
        pkt_o_ready = ready_mode ? ($urandom_range(0, 3) != 0) : ready_val;
    end

    // Monitor: packet handshakes pop the scoreboard; stalled outputs must hold.
    pkt_t snap;
    bit stalled_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev && pkt_o_valid) begin
                chk("stable_mask", pkt_o_mask, snap.mask);
                chk("stable_lanes", {pkt_o_ll, pkt_o_ml, pkt_o_offset[15:0]}, {snap.ll, snap.ml, snap.off[15:0]});
            end
            if (pkt_o_valid && !pkt_o_ready) begin
                snap.mask = pkt_o_mask; snap.ll = pkt_o_ll; snap.ml = pkt_o_ml; snap.off = pkt_o_offset;
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
            if (pkt_o_valid && pkt_o_ready) begin
                pkts_seen++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_packet", 1, 0);
                end else begin
                    pkt_t e;
                    e = exp_q.pop_front();
                    chk("pkt_mask", pkt_o_mask, e.mask);
                    chk("pkt_ll", pkt_o_ll, e.ll);
                    chk("pkt_ml", pkt_o_ml, e.ml);
                    chk("pkt_offset", pkt_o_offset, e.off);
                    chk("pkt_flags", {pkt_o_overlap, pkt_o_eoj, pkt_o_delim}, {e.ovl, e.eoj, e.delim});
                end
            end
        end
    end

    initial begin
        pkt_t s;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", pkt_o_valid, 0);
        chk("reset_fields", {pkt_o_mask, pkt_o_ll, pkt_o_overlap, pkt_o_eoj, pkt_o_delim}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", seq_i_ready, 1);

        // Full packets streaming with downstream always ready.
        stall_cnt = 0;
        for (int i = 0; i < 8; i++) send_rand(0, 0);
        chk("stream_no_stall", stall_cnt, 0);
        drain("drain_stream");

        // Partial packet closed by eoj.
        send(8'h11, 8'h21, 12'h301, 8'h00, 1'b0, 1'b0);
        send(8'h12, 8'h22, 12'h302, 8'h00, 1'b0, 1'b0);
        send(8'h13, 8'h23, 12'h303, 8'h05, 1'b1, 1'b0);
        drain("drain_eoj");

        // Single sequence with eoj and delim: one-cycle latency.
        send(8'h44, 8'h55, 12'h666, 8'h09, 1'b1, 1'b1);
        chk("eoj_delim_latency", {pkt_o_valid, pkt_o_mask, pkt_o_eoj, pkt_o_delim}, {1'b1, 4'b0001, 1'b1, 1'b1});
        drain("drain_eoj_delim");

        // Backpressure: one packet held in output, second pending.
        ready_val = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) send_rand(0, 0);
        chk("pending_blocks_input", seq_i_ready, 0);
        s.mask = pkt_o_mask; s.ll = pkt_o_ll;
        repeat (5) @(posedge clk);
        #1;
        chk("held_output", {pkt_o_valid, pkt_o_mask, pkt_o_ll}, {1'b1, s.mask, s.ll});
        chk("still_pending", seq_i_ready, 0);
        ready_val = 1'b1;
        for (int i = 0; i < 4; i++) send_rand(0, 0);
        drain("drain_backpressure");

        // Async reset mid-packet with output occupied.
        ready_val = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) send_rand(0, 0);
        chk("pre_reset_valid", pkt_o_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("reset_kills_valid", pkt_o_valid, 0);
        exp_q.delete();
        m_n = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready_val = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) send_rand(0, 0);
        drain("drain_after_reset");

        // Random traffic with random backpressure and random eoj/delim.
        ready_mode = 1'b1;
        for (int i = 0; i < 120; i++) send_rand(12, 12);
        ready_mode = 1'b0;
        ready_val = 1'b1;
        if (m_n != 0) send(8'h77, 8'h88, 12'h999, 8'h3c, 1'b1, 1'b0);
        drain("drain_random");

`ifdef SEQ_PACKER_TIMEOUT_EN
        begin
            int k;
            send(8'hA1, 8'hB1, 12'hC01, 8'h00, 1'b0, 1'b0);
            send(8'hA2, 8'hB2, 12'hC02, 8'h00, 1'b0, 1'b0);
            model_emit(m_n, 1'b0, 1'b0, '0);
            k = 0;
            for (int w = 1; w <= 200; w++) begin
                @(posedge clk); #1;
                if (pkt_o_valid) begin k = w; break; end
            end
            chk("timeout_latency", k, 65);
            drain("drain_timeout");
        end
`endif

        chk("packets_delivered_nonzero", (pkts_seen > 10), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
